// File: rtl/dp_pkg.sv
// Shared types and constants for the pair-compare sequencing controller.
package dp_pkg;

    localparam int DEPTH_A = 8;
    localparam int DEPTH_B = 4;
    localparam int AW      = 3;
    localparam int BW      = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PRIME = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Controller strobes and status, grouped so one default clears them all.
    typedef struct packed {
        logic load_ready;
        logic wea;
        logic inca;
        logic web;
        logic incb;
        logic busy;
        logic done;
    } ctrl_out_t;

endpackage

// File: rtl/dp_seq_cnt.sv
// Modulo-N up counter with enable; wrap is high on the enabled step from N-1 back to 0.
module dp_seq_cnt #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: hold, increment, or return to zero on the final step.
    always_comb begin
        // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
        cnt_d = cnt_q;
        wrap  = en && (cnt_q == LAST);
        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register, cleared together with the datapath counters.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/dp_seq_ctrl.sv
// Sequencer for the pair-compare datapath: load DEPTH_A bytes into A, then
// write DEPTH_A/2 add/sub results into B, alternating PRIME and WRITE.
module dp_seq_ctrl
    import dp_pkg::*;
#(
    parameter int DEPTH_A = dp_pkg::DEPTH_A,
    parameter int DEPTH_B = dp_pkg::DEPTH_B
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic load_valid,
    output logic load_ready,
    output logic WEA,
    output logic incA,
    output logic WEB,
    output logic incB,
    output logic busy,
    output logic done
);

    localparam int CAW = $clog2(DEPTH_A);
    localparam int CBW = $clog2(DEPTH_B);

    state_e    state_q;
    state_e    state_d;
    ctrl_out_t outs_c;

    logic           load_en;
    logic           load_wrap;
    logic [CAW-1:0] load_cnt;
    logic           pair_en;
    logic           pair_wrap;
    logic [CBW-1:0] pair_cnt;

    assign load_en = (state_q == LOAD) && load_valid;
    assign pair_en = (state_q == WRITE);

    dp_seq_cnt #(.N(DEPTH_A), .W(CAW)) u_load_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (load_en),
        .count (load_cnt),
        .wrap  (load_wrap)
    );

    dp_seq_cnt #(.N(DEPTH_B), .W(CBW)) u_pair_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (pair_en),
        .count (pair_cnt),
        .wrap  (pair_wrap)
    );

    // Next-state: the last accepted byte ends LOAD, the last pair write ends the compute phase.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (load_wrap) state_d = PRIME;
            PRIME:   state_d = WRITE;
            WRITE:   state_d = pair_wrap ? DONE : PRIME;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes decoded from state; only LOAD looks at load_valid, nothing looks at start.
    always_comb begin
        outs_c = '0;
        unique case (state_q)
            IDLE: ;
            LOAD: begin
                outs_c.load_ready = 1'b1;
                outs_c.wea        = load_valid;
                outs_c.inca       = load_valid;
                outs_c.busy       = 1'b1;
            end
            PRIME: begin
                outs_c.inca = 1'b1;
                outs_c.busy = 1'b1;
            end
            WRITE: begin
                outs_c.inca = 1'b1;
                outs_c.web  = 1'b1;
                outs_c.incb = 1'b1;
                outs_c.busy = 1'b1;
            end
            DONE: begin
                outs_c.done = 1'b1;
                outs_c.busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign load_ready = outs_c.load_ready;
    assign WEA        = outs_c.wea;
    assign incA       = outs_c.inca;
    assign WEB        = outs_c.web;
    assign incB       = outs_c.incb;
    assign busy       = outs_c.busy;
    assign done       = outs_c.done;

    // Both counters wrap back to zero by the end of a run, so IDLE always sees them cleared.
    a_counts_zero_in_idle: assert property (
        @(posedge clk) disable iff (rst)
        (state_q == IDLE) |-> (load_cnt == '0 && pair_cnt == '0)
    );

endmodule

// File: tb/tb_dp_seq_ctrl.sv
// Self-checking bench for dp_seq_ctrl with a behavioural model of the
// external datapath (memory A, previous-value register, add/sub, memory B).
module tb_dp_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic load_valid;
    logic load_ready, WEA, incA, WEB, incB, busy, done;

    always #5 clk = ~clk;

    dp_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .WEA        (WEA),
        .incA       (incA),
        .WEB        (WEB),
        .incB       (incB),
        .busy       (busy),
        .done       (done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int gcyc     = 0;
    int last_done;

    always @(posedge clk) gcyc <= gcyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {load_ready, WEA, incA, WEB, incB, busy, done}
    function automatic logic [6:0] outs();
        return {load_ready, WEA, incA, WEB, incB, busy, done};
    endfunction

    // Add when the second byte of a pair does not exceed the first, otherwise subtract.
    function automatic logic [7:0] pair_fn(input logic [7:0] a, input logic [7:0] b);
        return (b <= a) ? 8'(a + b) : 8'(b - a);
    endfunction

    // ---- external datapath model, driven only by the controller strobes ----
    logic [7:0] din;
    logic [7:0] mem_a [8];
    logic [7:0] mem_b [4];
    logic [2:0] addr_a;
    logic [1:0] addr_b;
    logic [7:0] prev;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_a <= '0;
            addr_b <= '0;
        end else begin
            if (WEA)  mem_a[addr_a] <= din;
            if (incA) addr_a <= addr_a + 3'd1;
            prev <= mem_a[addr_a];
            if (WEB)  mem_b[addr_b] <= pair_fn(prev, mem_a[addr_a]);
            if (incB) addr_b <= addr_b + 2'd1;
        end
    end

    logic [7:0] tbl [8] = '{8'd10, 8'd3, 8'd7, 8'd7, 8'd1, 8'd9, 8'd20, 8'd5};

    // One run, entered and left at posedge+1. Expected strobes come from the
    // run's phase: 8 accepted bytes, then 8 compute cycles (odd ones write B), then done.
    task automatic do_run(input int stall_pct, input bit use_tbl, input bit pulse_busy,
                          input bit hold_start, input int abort_step);
        logic [7:0] loaded [$];
        logic [6:0] exp;
        int n_loaded   = 0;
        int step       = 0;
        int load_cycles = 0;
        int wea_n = 0, inca_n = 0, web_n = 0, incb_n = 0;
        int cyc = 0;
        bit finished = 0;

        // start cycle, still IDLE
        start = 1'b1;
        load_valid = 1'($urandom_range(1));
        din = 8'($urandom);
        @(negedge clk);
        check("idle_start_cycle", outs(), 7'b0);
        @(posedge clk); #1;

        while (!finished && cyc < 300) begin
            cyc++;
            start = hold_start | (pulse_busy && (cyc == 5 || cyc == 12));
            load_valid = ($urandom_range(99) >= stall_pct);
            din = (use_tbl && n_loaded < 8) ? tbl[n_loaded] : 8'($urandom);

            if (n_loaded < 8)
                exp = {1'b1, load_valid, load_valid, 2'b00, 1'b1, 1'b0};
            else if (step < 8)
                exp = {2'b00, 1'b1, step[0], step[0], 1'b1, 1'b0};
            else
                exp = 7'b0000011;

            if (abort_step >= 0 && n_loaded == 8 && step == abort_step) begin
                #2;
                check("pre_reset_outs", outs(), exp);
                rst = 1'b1;
                #1;
                check("reset_same_cycle_outs", outs(), 7'b0);
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                #1;
                check("reset_idle_outs", outs(), 7'b0);
                @(posedge clk); #1;
                return;
            end

            @(negedge clk);
            check("run_outs", outs(), exp);
            wea_n  += int'(WEA);
            inca_n += int'(incA);
            web_n  += int'(WEB);
            incb_n += int'(incB);

            if (n_loaded < 8) begin
                load_cycles++;
                if (load_valid) begin
                    loaded.push_back(din);
                    n_loaded++;
                end
            end else if (step < 8) begin
                step++;
            end else begin
                last_done = gcyc;
                finished = 1;
            end
            @(posedge clk); #1;
        end

        check("run_finished_in_budget", 32'(finished), 32'd1);
        check("wea_count",  wea_n,  8);
        check("inca_count", inca_n, 16);
        check("web_count",  web_n,  4);
        check("incb_count", incb_n, 4);
        // start cycle + load-phase cycles + 8 compute + done, inclusive
        check("latency", cyc + 1, 1 + load_cycles + 8 + 1);
        if (stall_pct == 0) check("latency_min", cyc + 1, 18);
        check("addr_a_wrapped", addr_a, 0);
        check("addr_b_wrapped", addr_b, 0);
        if (loaded.size() == 8) begin
            for (int k = 0; k < 4; k++)
                check($sformatf("mem_b[%0d]", k), mem_b[k], pair_fn(loaded[2*k], loaded[2*k+1]));
        end

        if (!hold_start) begin
            start = 1'b0;
            @(negedge clk);
            check("post_done_idle", outs(), 7'b0);
            @(posedge clk); #1;
        end
    endtask

    int d1;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        load_valid = 1'b0;
        din = '0;
        #1;
        check("reset_outs", outs(), 7'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // idle with start low, load_valid wiggling
        repeat (10) begin
            load_valid = 1'($urandom_range(1));
            @(negedge clk);
            check("idle_outs", outs(), 7'b0);
            @(posedge clk); #1;
        end

        do_run(0,  1, 0, 0, -1);   // fixed data, continuous valid
        do_run(50, 0, 0, 0, -1);   // stalled load
        do_run(0,  0, 1, 0, -1);   // start pulses while busy
        do_run(30, 0, 0, 0, 3);    // reset in the second WRITE
        do_run(0,  1, 0, 0, -1);   // clean run after reset

        // start held high: IDLE + 8 load + 8 compute + DONE between done pulses
        do_run(0, 0, 0, 1, -1);
        d1 = last_done;
        do_run(0, 0, 0, 1, -1);
        check("back_to_back_period", last_done - d1, 18);
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        repeat (4) do_run(int'($urandom_range(60)), 0, 1'($urandom_range(1)), 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
